// File: rtl/traceback_unit_pkg.sv
// Shared constants, FSM encoding and trellis helper for the Viterbi traceback unit.
package traceback_unit_pkg;

  localparam int K         = 3;
  localparam int TB_DEPTH  = 16;
  localparam int NUM_STATE = 2 ** (K - 1);
  localparam int SW        = K - 1;
  localparam int CW        = $clog2(TB_DEPTH + 1);
  localparam int AW        = (TB_DEPTH > 1) ? $clog2(TB_DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_WR    = 2'd0,
    ST_TRACE = 2'd1,
    ST_OUT   = 2'd2,
    ST_DONE  = 2'd3
  } tb_state_e;

  // Predecessor of state s: drop the newest bit (MSB), shift in the survivor decision.
  function automatic logic [SW-1:0] prev_state(input logic [SW-1:0] s, input logic d);
    return {s[SW-2:0], d};
  endfunction

endpackage

// File: rtl/traceback_unit_tb_mem.sv
// Survivor decision memory: one synchronous write port, one asynchronous read port.
module tb_mem
  import traceback_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [AW-1:0]        waddr_i,
  input  logic [NUM_STATE-1:0] wdata_i,
  input  logic [AW-1:0]        raddr_i,
  output logic [NUM_STATE-1:0] rdata_o
);

  logic [NUM_STATE-1:0] mem_q [TB_DEPTH];

  // Contents are not reset; the write counter gates which columns are ever read.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/traceback_unit.sv
// Viterbi traceback: stores survivor columns, walks the path backward from the
// best state, then emits the decoded bits oldest-first.
module traceback_unit
  import traceback_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 i_en_td,
  input  logic                 i_en_t,
  input  logic [NUM_STATE-1:0] i_surv,
  input  logic [SW-1:0]        i_best_state,
  output logic                 o_td_full,
  output logic                 o_bit,
  output logic                 o_valid,
  output logic                 o_done
);

  tb_state_e            state_q, state_d;
  logic [CW-1:0]        wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]        out_idx_q, out_idx_d;
  logic [SW-1:0]        cur_state_q, cur_state_d;
  logic [TB_DEPTH-1:0]  bitbuf_q, bitbuf_d;
  logic                 bit_q, bit_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 mem_we;
  logic [NUM_STATE-1:0] mem_rdata;
  logic                 full;
  logic                 last_out;

  assign full     = (wr_cnt_q == CW'(TB_DEPTH));
  assign last_out = (CW'(out_idx_q) == (wr_cnt_q - CW'(1)));

  tb_mem u_mem (
    .clk     (clk),
    .we_i    (mem_we & en),
    .waddr_i (AW'(wr_cnt_q)),
    .wdata_i (i_surv),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    out_idx_d   = out_idx_q;
    cur_state_d = cur_state_q;
    bitbuf_d    = bitbuf_q;
    bit_d       = bit_q;
    valid_d     = valid_q;
    done_d      = done_q;
    mem_we      = 1'b0;

    unique case (state_q)
      ST_WR: begin
        // Traceback start outranks a simultaneous column write.
        if (i_en_t) begin
          if (wr_cnt_q == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            cur_state_d = i_best_state;
            rd_ptr_d    = AW'(wr_cnt_q - CW'(1));
            state_d     = ST_TRACE;
          end
        end else if (i_en_td && !full) begin
          mem_we   = 1'b1;
          wr_cnt_d = wr_cnt_q + CW'(1);
        end
      end

      ST_TRACE: begin
        bitbuf_d[rd_ptr_q] = cur_state_q[SW-1];
        cur_state_d        = prev_state(cur_state_q, mem_rdata[cur_state_q]);
        if (rd_ptr_q == '0) begin
          out_idx_d = '0;
          state_d   = ST_OUT;
        end else begin
          rd_ptr_d = rd_ptr_q - AW'(1);
        end
      end

      ST_OUT: begin
        bit_d     = bitbuf_q[out_idx_q];
        valid_d   = 1'b1;
        out_idx_d = out_idx_q + AW'(1);
        if (last_out) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        valid_d = 1'b0;
        done_d  = 1'b1;
      end

      default: state_d = ST_WR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_WR;
      wr_cnt_q    <= '0;
      rd_ptr_q    <= '0;
      out_idx_q   <= '0;
      cur_state_q <= '0;
      bit_q       <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else if (en) begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      out_idx_q   <= out_idx_d;
      cur_state_q <= cur_state_d;
      bit_q       <= bit_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end

  // Decoded-bit buffer is pure data: always rewritten by TRACE before OUT reads it.
  always_ff @(posedge clk) begin
    if (en) begin
      bitbuf_q <= bitbuf_d;
    end
  end

  assign o_td_full = full;
  assign o_bit     = bit_q;
  assign o_valid   = valid_q;
  assign o_done    = done_q;

endmodule

// File: tb/tb_traceback_unit.sv
// Directed bench for traceback_unit: survivor columns are built from known
// input bit sequences, so the decoded output must reproduce those bits.
module tb_traceback_unit;
  import traceback_unit_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic                 i_en_td;
  logic                 i_en_t;
  logic [NUM_STATE-1:0] i_surv;
  logic [SW-1:0]        i_best_state;
  logic                 o_td_full;
  logic                 o_bit;
  logic                 o_valid;
  logic                 o_done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          n;
    logic [15:0] u;
    int          extra;
    bit          both;
  } vec_t;

  vec_t vecs [6];

  traceback_unit dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .i_en_td      (i_en_td),
    .i_en_t       (i_en_t),
    .i_surv       (i_surv),
    .i_best_state (i_best_state),
    .o_td_full    (o_td_full),
    .o_bit        (o_bit),
    .o_valid      (o_valid),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Column t: true state {u_t,u_t-1} carries decision u_t-2; other states random.
  function automatic logic [NUM_STATE-1:0] col(input logic [15:0] u, input int t);
    logic [NUM_STATE-1:0] c;
    logic um1, um2;
    int s;
    c   = NUM_STATE'($urandom);
    um1 = (t >= 1) ? u[t-1] : 1'b0;
    um2 = (t >= 2) ? u[t-2] : 1'b0;
    s   = {u[t], um1};
    c[s] = um2;
    return c;
  endfunction

  function automatic logic [SW-1:0] best(input logic [15:0] u, input int n);
    logic um1;
    um1 = (n >= 2) ? u[n-2] : 1'b0;
    return {u[n-1], um1};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b1; i_en_td = 1'b0; i_en_t = 1'b0;
    i_surv = '0; i_best_state = '0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic write_col(input logic [NUM_STATE-1:0] c);
    i_en_td = 1'b1; i_surv = c;
    tick();
    i_en_td = 1'b0;
  endtask

  task automatic start(input logic [SW-1:0] b, input bit both);
    i_en_t = 1'b1; i_en_td = both; i_surv = NUM_STATE'($urandom); i_best_state = b;
    tick();
    i_en_t = 1'b0; i_en_td = 1'b0;
  endtask

  task automatic collect(input int n, input logic [15:0] exp_bits, input int freeze_at, input string tag);
    int cnt, first_c, last_c, done_c;
    logic [15:0] got, mask;
    logic held;
    cnt = 0; first_c = -1; last_c = -1; done_c = -1; got = '0;
    mask = (n >= 16) ? 16'hFFFF : 16'((32'h1 << n) - 1);
    for (int c = 1; c <= 80 && done_c < 0; c++) begin
      tick();
      if (o_valid) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        if (cnt < 16) got[cnt] = o_bit;
        cnt++;
        if (cnt == freeze_at) begin
          held = o_bit;
          en = 1'b0;
          for (int f = 0; f < 3; f++) begin
            tick();
            check($sformatf("%s freeze valid", tag), 32'(o_valid), 32'd1);
            check($sformatf("%s freeze bit", tag), 32'(o_bit), 32'(held));
          end
          en = 1'b1;
        end
      end
      if (o_done) done_c = c;
    end
    check($sformatf("%s bit count", tag), 32'(cnt), 32'(n));
    check($sformatf("%s bits", tag), 32'(got & mask), 32'(exp_bits & mask));
    check($sformatf("%s latency", tag), 32'(first_c), 32'(n + 1));
    check($sformatf("%s done timing", tag), 32'(done_c), 32'(last_c + 1));
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    do_reset();
    for (int t = 0; t < v.n; t++) begin
      write_col(col(v.u, t));
      check($sformatf("%s td_full after write %0d", tag, t + 1), 32'(o_td_full),
            32'((t + 1) == TB_DEPTH));
    end
    for (int e = 0; e < v.extra; e++) begin
      write_col(NUM_STATE'($urandom));
      check($sformatf("%s td_full extra write", tag), 32'(o_td_full), 32'd1);
    end
    start(best(v.u, v.n), v.both);
    collect(v.n, v.u, 0, tag);
    i_en_t = 1'b1; i_en_td = 1'b1;
    tick(); tick();
    i_en_t = 1'b0; i_en_td = 1'b0;
    check($sformatf("%s done sticky", tag), 32'(o_done), 32'd1);
    check($sformatf("%s no valid in done", tag), 32'(o_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{n: 6,  u: 16'h000D, extra: 0, both: 1'b0};
    vecs[1] = '{n: 16, u: 16'hA5C3, extra: 1, both: 1'b0};
    vecs[2] = '{n: 4,  u: 16'h0006, extra: 0, both: 1'b1};
    vecs[3] = '{n: 1,  u: 16'h0001, extra: 0, both: 1'b0};
    vecs[4] = '{n: 9,  u: 16'h01B2, extra: 0, both: 1'b0};
    vecs[5] = '{n: 16, u: 16'h7E18, extra: 2, both: 1'b0};

    rst = 1'b0; en = 1'b1; i_en_td = 1'b0; i_en_t = 1'b0;
    i_surv = '0; i_best_state = '0;
    @(negedge clk);
    check("reset o_valid", 32'(o_valid), 32'd0);
    check("reset o_bit", 32'(o_bit), 32'd0);
    check("reset o_done", 32'(o_done), 32'd0);
    check("reset o_td_full", 32'(o_td_full), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset in the middle of TRACE with a full memory.
    do_reset();
    for (int t = 0; t < 16; t++) write_col(col(16'h1234, t));
    check("pre-reset td_full", 32'(o_td_full), 32'd1);
    start(best(16'h1234, 16), 1'b0);
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    check("midtrace rst td_full", 32'(o_td_full), 32'd0);
    check("midtrace rst valid", 32'(o_valid), 32'd0);
    check("midtrace rst done", 32'(o_done), 32'd0);
    check("midtrace rst bit", 32'(o_bit), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("post-reset td_full", 32'(o_td_full), 32'd0);

    // Empty block right after reset: wr_cnt must be 0.
    start(2'b11, 1'b0);
    check("empty done next cycle", 32'(o_done), 32'd1);
    check("empty no valid", 32'(o_valid), 32'd0);
    i_en_td = 1'b1; i_en_t = 1'b1;
    for (int c = 0; c < 4; c++) begin
      i_surv = NUM_STATE'($urandom);
      tick();
      check("empty done hold valid", 32'(o_valid), 32'd0);
      check("empty done hold done", 32'(o_done), 32'd1);
    end
    i_en_td = 1'b0; i_en_t = 1'b0;
    check("empty done ignores writes", 32'(o_td_full), 32'd0);

    // Reset while OUT is driving a 1 bit.
    do_reset();
    for (int t = 0; t < 5; t++) write_col(col(16'h001F, t));
    start(best(16'h001F, 5), 1'b0);
    begin
      int w;
      w = 0;
      while (!o_valid && w < 20) begin
        tick();
        w++;
      end
    end
    check("midout pre valid", 32'(o_valid), 32'd1);
    check("midout pre bit", 32'(o_bit), 32'd1);
    rst = 1'b0;
    #1;
    check("midout rst valid", 32'(o_valid), 32'd0);
    check("midout rst bit", 32'(o_bit), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Freeze for 3 cycles mid-OUT after the 3rd emitted bit.
    do_reset();
    for (int t = 0; t < 10; t++) write_col(col(16'h0356, t));
    start(best(16'h0356, 10), 1'b0);
    collect(10, 16'h0356, 3, "freeze");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
